// File: rtl/axi_regs_master.sv
// Single-outstanding AXI3 register master: turns one read/write request into a
// one-beat AXI transaction and returns data, response code and a protocol-error flag.
module axi_regs_master #(
    parameter logic [11:0] AXI_ID = 12'h0
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_we,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_err,

    output logic [31:0] AWADDR,
    output logic        AWVALID,
    output logic [11:0] AWID,
    output logic [3:0]  AWLEN,
    output logic [1:0]  AWSIZE,
    output logic [1:0]  AWBURST,
    input  logic        AWREADY,

    output logic [31:0] WDATA,
    output logic        WVALID,
    output logic [11:0] WID,
    output logic        WLAST,
    output logic [3:0]  WSTRB,
    input  logic        WREADY,

    input  logic        BVALID,
    output logic        BREADY,
    input  logic [11:0] BID,
    input  logic [1:0]  BRESP,

    output logic [31:0] ARADDR,
    output logic        ARVALID,
    output logic [11:0] ARID,
    output logic [3:0]  ARLEN,
    output logic [1:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    input  logic        ARREADY,

    input  logic [31:0] RDATA,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic [11:0] RID,
    input  logic        RLAST,
    input  logic [1:0]  RRESP
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        BWAIT,
        RADDR,
        RWAIT,
        RSP
    } state_t;

    state_t      state, state_nx;
    logic        awvalid_q, awvalid_nx;
    logic        wvalid_q, wvalid_nx;
    logic        arvalid_q, arvalid_nx;
    logic        rsp_valid_q, rsp_valid_nx;
    logic        rsp_we_q, rsp_we_nx;
    logic [31:0] rsp_rdata_q, rsp_rdata_nx;
    logic [1:0]  rsp_resp_q, rsp_resp_nx;
    logic        rsp_err_q, rsp_err_nx;
    logic [31:0] awaddr_q, awaddr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [3:0]  wstrb_q, wstrb_nx;
    logic [31:0] araddr_q, araddr_nx;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_err_q   <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
        end else begin
            state       <= state_nx;
            awvalid_q   <= awvalid_nx;
            wvalid_q    <= wvalid_nx;
            arvalid_q   <= arvalid_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_we_q    <= rsp_we_nx;
            rsp_rdata_q <= rsp_rdata_nx;
            rsp_resp_q  <= rsp_resp_nx;
            rsp_err_q   <= rsp_err_nx;
            awaddr_q    <= awaddr_nx;
            wdata_q     <= wdata_nx;
            wstrb_q     <= wstrb_nx;
            araddr_q    <= araddr_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        awvalid_nx   = awvalid_q;
        wvalid_nx    = wvalid_q;
        arvalid_nx   = arvalid_q;
        rsp_valid_nx = rsp_valid_q;
        rsp_we_nx    = rsp_we_q;
        rsp_rdata_nx = rsp_rdata_q;
        rsp_resp_nx  = rsp_resp_q;
        rsp_err_nx   = rsp_err_q;
        awaddr_nx    = awaddr_q;
        wdata_nx     = wdata_q;
        wstrb_nx     = wstrb_q;
        araddr_nx    = araddr_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    rsp_we_nx = req_we;
                    if (req_we) begin
                        state_nx   = WRITE;
                        awaddr_nx  = req_addr;
                        wdata_nx   = req_wdata;
                        wstrb_nx   = req_wstb;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                    end else begin
                        state_nx   = RADDR;
                        araddr_nx  = req_addr;
                        arvalid_nx = 1'b1;
                    end
                end
            end
            WRITE: begin
                // AW and W complete independently; leave once neither is still pending
                if (AWREADY) awvalid_nx = 1'b0;
                if (WREADY)  wvalid_nx  = 1'b0;
                if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY))
                    state_nx = BWAIT;
            end
            BWAIT: begin
                if (BVALID) begin
                    rsp_rdata_nx = '0;
                    rsp_resp_nx  = BRESP;
                    rsp_err_nx   = (BID != AXI_ID);
                    rsp_valid_nx = 1'b1;
                    state_nx     = RSP;
                end
            end
            RADDR: begin
                if (ARREADY) begin
                    arvalid_nx = 1'b0;
                    state_nx   = RWAIT;
                end
            end
            RWAIT: begin
                if (RVALID) begin
                    rsp_rdata_nx = RDATA;
                    rsp_resp_nx  = RRESP;
                    rsp_err_nx   = (RID != AXI_ID) || !RLAST;
                    rsp_valid_nx = 1'b1;
                    state_nx     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign BREADY    = (state == BWAIT);
    assign RREADY    = (state == RWAIT);

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_err   = rsp_err_q;

    assign AWADDR  = awaddr_q;
    assign AWVALID = awvalid_q;
    assign AWID    = AXI_ID;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 2'b10;
    assign AWBURST = 2'b01;

    assign WDATA  = wdata_q;
    assign WVALID = wvalid_q;
    assign WID    = AXI_ID;
    assign WLAST  = 1'b1;
    assign WSTRB  = wstrb_q;

    assign ARADDR  = araddr_q;
    assign ARVALID = arvalid_q;
    assign ARID    = AXI_ID;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 2'b10;
    assign ARBURST = 2'b01;

endmodule

// File: tb/tb_axi_regs_master.sv
// Bench for axi_regs_master: directed timing scenarios plus randomized transactions,
// each checked against a transaction-level model of the expected channel activity.
module tb_axi_regs_master;

    localparam logic [11:0] ID = 12'h5A3;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstb;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [11:0] AWID, WID, BID, ARID, RID;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [1:0]  AWSIZE, AWBURST, ARSIZE, ARBURST, BRESP, RRESP;

    int checks   = 0;
    int failures = 0;

    axi_regs_master #(.AXI_ID(ID)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstb(req_wstb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WID(WID), .WLAST(WLAST),
        .WSTRB(WSTRB), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARID(ARID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RID(RID),
        .RLAST(RLAST), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // dly >= 0: asserted from that cycle on; dly < 0: coin flip every cycle
    function automatic bit go(input int dly, input int cyc);
        if (dly >= 0) return cyc >= dly;
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic idle_slave;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BVALID = 1'b0; RVALID = 1'b0; rsp_ready = 1'b0;
    endtask

    // One request end to end. Cycle 1 is the first cycle after acceptance.
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstb, input logic [11:0] sid, input bit slast,
                           input logic [1:0] sresp, input logic [31:0] srdata,
                           input int aw_dly, input int w_dly, input int ar_dly,
                           input int s_dly, input int rsp_dly, output int rsp_cyc);
        bit aw_seen = 0, w_seen = 0, ar_seen = 0, s_seen = 0, s_up = 0, done = 0;
        bit aw_hs, w_hs, ar_hs, s_hs, r_hs;
        logic [31:0] exp_rdata;
        bit exp_err;
        int cyc, wait_cyc;
        exp_rdata = we ? 32'h0 : srdata;
        exp_err   = (sid != ID) || (!we && !slast);
        rsp_cyc   = -1;

        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstb = wstb;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin
            tick;
            wait_cyc++;
        end
        chk("req_ready_at_request", req_ready, 1'b1);
        tick;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstb  = 4'($urandom);

        cyc = 1;
        while (!done && cyc < 200) begin
            chk("req_ready_busy", req_ready, 1'b0);
            if (we) begin
                chk("awvalid", AWVALID, !aw_seen);
                chk("wvalid", WVALID, !w_seen);
                chk("arvalid_in_write", ARVALID, 1'b0);
                chk("bready", BREADY, aw_seen && w_seen && !s_seen);
                chk("rready_in_write", RREADY, 1'b0);
                if (AWVALID) chk("awaddr", AWADDR, addr);
                if (WVALID) begin
                    chk("wdata", WDATA, wdata);
                    chk("wstrb", WSTRB, wstb);
                end
            end else begin
                chk("arvalid", ARVALID, !ar_seen);
                chk("awvalid_in_read", AWVALID, 1'b0);
                chk("wvalid_in_read", WVALID, 1'b0);
                chk("rready", RREADY, ar_seen && !s_seen);
                chk("bready_in_read", BREADY, 1'b0);
                if (ARVALID) chk("araddr", ARADDR, addr);
            end
            chk("rsp_valid", rsp_valid, s_seen);
            if (s_seen) begin
                if (rsp_cyc < 0) rsp_cyc = cyc;
                chk("rsp_we", rsp_we, we);
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_resp", rsp_resp, sresp);
                chk("rsp_err", rsp_err, exp_err);
            end

            AWREADY = go(aw_dly, cyc);
            WREADY  = go(w_dly, cyc);
            ARREADY = go(ar_dly, cyc);
            if ((we ? (aw_seen && w_seen) : ar_seen) && !s_seen && go(s_dly, cyc)) s_up = 1;
            BVALID = we && s_up;
            RVALID = !we && s_up;
            BID    = BVALID ? sid : 12'($urandom);
            BRESP  = BVALID ? sresp : 2'($urandom);
            RID    = RVALID ? sid : 12'($urandom);
            RRESP  = RVALID ? sresp : 2'($urandom);
            RDATA  = RVALID ? srdata : $urandom;
            RLAST  = RVALID ? slast : 1'($urandom);
            rsp_ready = go(rsp_dly, cyc);

            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            ar_hs = ARVALID && ARREADY;
            s_hs  = s_up && (we ? BREADY : RREADY);
            r_hs  = rsp_valid && rsp_ready;
            tick;
            cyc++;
            if (aw_hs) aw_seen = 1;
            if (w_hs)  w_seen = 1;
            if (ar_hs) ar_seen = 1;
            if (s_hs) begin
                s_seen = 1;
                s_up   = 0;
            end
            if (r_hs) done = 1;
        end
        idle_slave();
        chk("txn_completed", done, 1'b1);
        chk("req_ready_after_rsp", req_ready, 1'b1);
        chk("rsp_valid_after_rsp", rsp_valid, 1'b0);
        chk("rsp_rdata_held", rsp_rdata, exp_rdata);
    endtask

    int rc;
    logic [31:0] a, d;
    bit w;

    initial begin
        ARESETN = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstb = '0;
        idle_slave();
        BID = '0; BRESP = '0; RID = '0; RRESP = '0; RDATA = '0; RLAST = 1'b0;
        #23;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_awvalid", AWVALID, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_awaddr", AWADDR, 32'h0);
        chk("const_axsize", {AWLEN, AWSIZE, AWBURST, ARLEN, ARSIZE, ARBURST, WLAST},
            {4'd0, 2'b10, 2'b01, 4'd0, 2'b10, 2'b01, 1'b1});
        chk("const_ids", {AWID, WID, ARID}, {ID, ID, ID});
        ARESETN = 1'b1;
        tick;

        // minimum-latency write
        run_txn(1, 32'h14, 32'hDEADBEEF, 4'hF, ID, 1, 2'b00, 32'h0, 0, 0, 0, 0, 0, rc);
        chk("write_rsp_cycle", rc, 3);

        // skewed write channels
        run_txn(1, 32'h20, 32'hA5A5_0F0F, 4'h3, ID, 1, 2'b00, 32'h0, 5, 1, 0, 0, 0, rc);
        chk("skew_rsp_cycle", rc, 7);

        // read with wait states
        run_txn(0, 32'h40, 32'h0, 4'h0, ID, 1, 2'b00, 32'h1234_5678, 0, 0, 3, 7, 0, rc);
        chk("read_rsp_cycle", rc, 8);
        chk("read_rdata", rsp_rdata, 32'h1234_5678);

        // read with RLAST low
        run_txn(0, 32'h44, 32'h0, 4'h0, ID, 0, 2'b00, 32'hCAFE_F00D, -1, -1, -1, -1, -1, rc);
        chk("rlast_err", rsp_err, 1'b1);

        // write with wrong BID and SLVERR
        run_txn(1, 32'h48, 32'h1, 4'h1, ID ^ 12'h1, 1, 2'b10, 32'h0, -1, -1, -1, -1, -1, rc);
        chk("bid_err", rsp_err, 1'b1);
        chk("bid_resp", rsp_resp, 2'b10);

        // response backpressure for 10 cycles
        run_txn(1, 32'h4C, 32'h7777_8888, 4'hC, ID, 1, 2'b01, 32'h0, 0, 0, -1, 0, 13, rc);
        chk("bp_rsp_cycle", rc, 3);

        // asynchronous reset while in BWAIT
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'h55; req_wstb = 4'hF;
        AWREADY = 1'b1; WREADY = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        chk("pre_reset_bready", BREADY, 1'b1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("async_bready", BREADY, 1'b0);
        chk("async_valids", {AWVALID, WVALID, ARVALID, rsp_valid}, 4'b0);
        chk("async_req_ready", req_ready, 1'b1);
        chk("async_regs", {AWADDR, WDATA, rsp_we}, 65'h0);
        idle_slave();
        tick;
        #2;
        ARESETN = 1'b1;
        tick;
        run_txn(0, 32'h90, 32'h0, 4'h0, ID, 1, 2'b00, 32'h0BAD_F00D, 0, 0, 0, 0, 0, rc);
        chk("post_reset_read_cycle", rc, 3);

        // randomized transactions
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom);
            a = $urandom & 32'hFFFF_FFFC;
            d = $urandom;
            run_txn(w, a, d, 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? (ID ^ 12'(1 << $urandom_range(0, 11))) : ID,
                    $urandom_range(0, 3) != 0, 2'($urandom), $urandom,
                    -1, -1, -1, -1, -1, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
